// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a 2-entry skid buffer, valid/ready handshake and flush.
// Optional stall/bubble performance counter is enabled with `define ID_EX_BUBBLE_CNT_EN.
module id_ex_skid_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               id_valid_i,
  output logic               id_ready_o,
  input  logic [DATA_W-1:0]  id_pc_i,
  input  logic [DATA_W-1:0]  id_imm_i,
  input  logic [DATA_W-1:0]  id_rs1_data_i,
  input  logic [DATA_W-1:0]  id_rs2_data_i,
  input  logic [RADDR_W-1:0] id_rd_addr_i,
  input  logic [CTRL_W-1:0]  id_ctrl_i,
  output logic               ex_valid_o,
  input  logic               ex_ready_i,
  output logic [DATA_W-1:0]  ex_pc_o,
  output logic [DATA_W-1:0]  ex_imm_o,
  output logic [DATA_W-1:0]  ex_rs1_data_o,
  output logic [DATA_W-1:0]  ex_rs2_data_o,
  output logic [RADDR_W-1:0] ex_rd_addr_o,
  output logic [CTRL_W-1:0]  ex_ctrl_o
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]        perf_bubble_cnt_o
`endif
);

  localparam int BUNDLE_W = 4 * DATA_W + RADDR_W + CTRL_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [BUNDLE_W-1:0] main_q, skid_q, in_bundle;
  logic accept, consume;
  logic load_main_in, load_main_skid, load_skid;

  assign in_bundle = {id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i, id_rd_addr_i, id_ctrl_i};

  // Ready depends only on the state register, so ex_ready_i never reaches id_ready_o.
  assign id_ready_o = (state_q != FULL);
  assign ex_valid_o = (state_q != EMPTY);
  assign accept     = id_valid_i & id_ready_o;
  assign consume    = ex_valid_o & ex_ready_i;

  assign {ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, ex_ctrl_o} = main_q;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          case ({accept, consume})
            2'b11: load_main_in = 1'b1;
            2'b10: begin
              state_d   = FULL;
              load_skid = 1'b1;
            end
            2'b01: state_d = EMPTY;
            default: state_d = ONE;
          endcase
        end
        FULL: begin
          if (consume) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Data registers keep their contents across a flush; only the state marks them invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_bundle;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_bundle;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      bubble_cnt_q <= '0;
    else if (ex_ready_i && !ex_valid_o && (bubble_cnt_q != 32'hFFFF_FFFF))
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
  end

  assign perf_bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
